// File: rtl/jtag_config_bridge_pkg.sv
// Shared definitions for the JTAG configuration bridge: TAP states,
// instruction codes, data-register widths and the TAP next-state rule.
package jtag_config_bridge_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_CONFIG
    } dr_sel_e;

    localparam logic [3:0] INSTR_IDCODE = 4'b0001;
    localparam logic [3:0] INSTR_CONFIG = 4'b0010;
    localparam logic [3:0] INSTR_BYPASS = 4'b1111;
    localparam logic [3:0] IR_CAPTURE   = 4'b0101;

    localparam int CONFIG_DR_W = 64;
    localparam int IDCODE_DR_W = 32;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TAP_TLR:      return tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      return tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   return tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: return tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: return tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: return tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   return tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   return tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: return tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: return tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: return tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   return tms ? TAP_SEL_DR   : TAP_RTI;
            default:      return TAP_TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_config_bridge_tap_fsm.sv
// IEEE 1149.1 TAP controller, stepped once per oversampled tck rising edge.
module jtag_tap_fsm
    import jtag_config_bridge_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       tck_rise,
    input  logic       tms,
    input  logic       trst,
    output logic [3:0] state
);

    tap_state_e state_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= TAP_TLR;
        end else if (trst) begin
            state_q <= TAP_TLR;
        end else if (tck_rise) begin
            state_q <= tap_next(state_q, tms);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_config_bridge.sv
// JTAG-to-config bridge: oversamples the JTAG pins on clk_in and exposes a
// 64-bit CONFIG data register as an addr/data pair with a one-cycle strobe.
module jtag_config_bridge
    import jtag_config_bridge_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int          IR_WIDTH     = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        trst_n,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic [31:0] config_addr_out,
    output logic [31:0] config_data_out,
    output logic        config_valid_out
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CONFIG = IR_WIDTH'(INSTR_CONFIG);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS = IR_WIDTH'(INSTR_BYPASS);
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);

    // Pin order in the synchroniser: {trst_n, tck, tms, tdi}
    logic [3:0] sync1_q, sync2_q;
    logic       tck_prev_q;
    logic       trst_s, tck_s, tms_s, tdi_s;
    logic       tck_rise, tck_fall;

    logic [1:0]             arm_q, arm_d;
    logic                   rise_q, rise_d;
    logic [IR_WIDTH-1:0]    ir_q, ir_d;
    logic [IR_WIDTH-1:0]    ir_sh_q, ir_sh_d;
    logic [CONFIG_DR_W-1:0] dr_q, dr_d;
    logic                   tdo_q, tdo_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   valid_q, valid_d;

    logic [3:0] state_raw;
    tap_state_e state;
    dr_sel_e    dr_sel;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            sync1_q    <= {trst_n, tck, tms, tdi};
            sync2_q    <= sync1_q;
            tck_prev_q <= sync2_q[2];
        end
    end

    assign trst_s = ~sync2_q[3];
    assign tck_s  = sync2_q[2];
    assign tms_s  = sync2_q[1];
    assign tdi_s  = sync2_q[0];

    // Edges are ignored until the synchroniser has refilled after reset.
    assign tck_rise = (arm_q == 2'd3) &  tck_s & ~tck_prev_q;
    assign tck_fall = (arm_q == 2'd3) & ~tck_s &  tck_prev_q;

    jtag_tap_fsm u_tap (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .tck_rise (tck_rise),
        .tms      (tms_s),
        .trst     (trst_s),
        .state    (state_raw)
    );

    assign state  = tap_state_e'(state_raw);
    assign dr_sel = (ir_q == IR_IDCODE) ? DR_IDCODE :
                    (ir_q == IR_CONFIG) ? DR_CONFIG :
                    (ir_q == IR_BYPASS) ? DR_BYPASS : DR_BYPASS;

    always_comb begin
        arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        rise_d  = tck_rise & ~trst_s;
        ir_d    = ir_q;
        ir_sh_d = ir_sh_q;
        dr_d    = dr_q;
        tdo_d   = tdo_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = 1'b0;

        if (state == TAP_TLR) begin
            ir_d = IR_IDCODE;
        end

        // Capture/shift act on the state the TAP is leaving at this edge.
        if (tck_rise && !trst_s) begin
            case (state)
                TAP_CAP_IR:   ir_sh_d = IR_CAP;
                TAP_SHIFT_IR: ir_sh_d = {tdi_s, ir_sh_q[IR_WIDTH-1:1]};
                TAP_CAP_DR: begin
                    case (dr_sel)
                        DR_IDCODE: dr_d = {32'd0, IDCODE_VALUE};
                        DR_CONFIG: dr_d = {addr_q, data_q};
                        default:   dr_d = '0;
                    endcase
                end
                TAP_SHIFT_DR: begin
                    dr_d = dr_q >> 1;
                    case (dr_sel)
                        DR_IDCODE: dr_d[IDCODE_DR_W-1] = tdi_s;
                        DR_CONFIG: dr_d[CONFIG_DR_W-1] = tdi_s;
                        default:   dr_d[0]             = tdi_s;
                    endcase
                end
                default: ;
            endcase
        end

        // rise_q marks the cycle in which the TAP has just entered its new state.
        if (rise_q && !trst_s) begin
            if (state == TAP_UPD_IR) begin
                ir_d = ir_sh_q;
            end
            if (state == TAP_UPD_DR && dr_sel == DR_CONFIG) begin
                addr_d  = dr_q[63:32];
                data_d  = dr_q[31:0];
                valid_d = 1'b1;
            end
        end

        if (state == TAP_SHIFT_DR) begin
            if (tck_fall) tdo_d = dr_q[0];
        end else if (state == TAP_SHIFT_IR) begin
            if (tck_fall) tdo_d = ir_sh_q[0];
        end else begin
            tdo_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            arm_q   <= '0;
            rise_q  <= 1'b0;
            ir_q    <= IR_IDCODE;
            ir_sh_q <= '0;
            dr_q    <= '0;
            tdo_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            arm_q   <= arm_d;
            rise_q  <= rise_d;
            ir_q    <= ir_d;
            ir_sh_q <= ir_sh_d;
            dr_q    <= dr_d;
            tdo_q   <= tdo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tdo              = tdo_q;
    assign config_addr_out  = addr_q;
    assign config_data_out  = data_q;
    assign config_valid_out = valid_q;

endmodule
